// File: rtl/param_reg_file.sv
// NUM_REGS x WIDTH register file: clear / lane-masked load / dec / inc on every enabled register,
// two combinational read ports, registered wrap/zero. Optional macro RF_BYPASS_EN: reads show next state.
module param_reg_file_cell #(
  parameter int WIDTH     = 16,
  parameter int LANE_W    = 8,
  parameter int NUM_LANES = 2
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 we_i,
  input  logic [1:0]           fun_sel_i,
  input  logic [WIDTH-1:0]     in_i,
  input  logic [NUM_LANES-1:0] lane_en_i,
  output logic [WIDTH-1:0]     q_o,
  output logic [WIDTH-1:0]     d_o,
  output logic                 wrap_o
);
  logic [WIDTH-1:0] r_q, r_d;

  // r_d is what this register would hold if written this cycle
  always_comb begin
    r_d    = r_q;
    wrap_o = 1'b0;
    case (fun_sel_i)
      2'b00: r_d = '0;
      2'b01: begin
        for (int k = 0; k < NUM_LANES; k++)
          if (lane_en_i[k]) r_d[k*LANE_W +: LANE_W] = in_i[k*LANE_W +: LANE_W];
      end
      2'b10: begin
        r_d    = r_q - WIDTH'(1);
        wrap_o = (r_q == '0);
      end
      default: begin
        r_d    = r_q + WIDTH'(1);
        wrap_o = &r_q;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)   r_q <= '0;
    else if (we_i) r_q <= r_d;
  end

  assign q_o = r_q;
  assign d_o = r_d;
endmodule

module param_reg_file #(
  parameter  int WIDTH     = 16,
  parameter  int NUM_REGS  = 8,
  parameter  int LANE_W    = 8,
  localparam int NUM_LANES = WIDTH / LANE_W,
  localparam int SEL_W     = $clog2(NUM_REGS)
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [WIDTH-1:0]     in_i,
  input  logic [NUM_LANES-1:0] lane_en_i,
  input  logic [1:0]           fun_sel_i,
  input  logic                 en_i,
  input  logic [NUM_REGS-1:0]  reg_en_i,
  input  logic [SEL_W-1:0]     O1Sel_i,
  input  logic [SEL_W-1:0]     O2Sel_i,
  output logic [WIDTH-1:0]     O1_o,
  output logic [WIDTH-1:0]     O2_o,
  output logic                 wrap_o,
  output logic                 zero_o
);
  localparam int DEPTH = 1 << SEL_W;

  logic [NUM_REGS-1:0][WIDTH-1:0] q, d;
  logic [NUM_REGS-1:0]            wr, cell_wrap;
  logic [DEPTH-1:0][WIDTH-1:0]    rd_q;
  logic                           wrap_q, wrap_d, zero_q, zero_d, any_we;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign wr[i] = en_i & reg_en_i[i];
    param_reg_file_cell #(.WIDTH(WIDTH), .LANE_W(LANE_W), .NUM_LANES(NUM_LANES)) u_cell (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .we_i      (wr[i]),
      .fun_sel_i (fun_sel_i),
      .in_i      (in_i),
      .lane_en_i (lane_en_i),
      .q_o       (q[i]),
      .d_o       (d[i]),
      .wrap_o    (cell_wrap[i])
    );
  end

  // Selects past NUM_REGS land on zero-filled padding entries
  for (genvar i = 0; i < DEPTH; i++) begin : g_pad
    if (i < NUM_REGS) begin : g_real
      assign rd_q[i] = q[i];
    end else begin : g_zero
      assign rd_q[i] = '0;
    end
  end

  assign any_we = en_i & (|reg_en_i);

  always_comb begin
    wrap_d = 1'b0;
    zero_d = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_en_i[i]) begin
        wrap_d = wrap_d | cell_wrap[i];
        zero_d = zero_d | (d[i] == '0);
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wrap_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (any_we) begin
      wrap_q <= wrap_d;
      zero_q <= zero_d;
    end
  end

  assign wrap_o = wrap_q;
  assign zero_o = zero_q;

`ifdef RF_BYPASS_EN
  logic [DEPTH-1:0][WIDTH-1:0] rd_d;
  logic [DEPTH-1:0]            rd_we;
  for (genvar i = 0; i < DEPTH; i++) begin : g_byp
    if (i < NUM_REGS) begin : g_real
      assign rd_d[i]  = d[i];
      assign rd_we[i] = wr[i];
    end else begin : g_zero
      assign rd_d[i]  = '0;
      assign rd_we[i] = 1'b0;
    end
  end
  assign O1_o = rd_we[O1Sel_i] ? rd_d[O1Sel_i] : rd_q[O1Sel_i];
  assign O2_o = rd_we[O2Sel_i] ? rd_d[O2Sel_i] : rd_q[O2Sel_i];
`else
  assign O1_o = rd_q[O1Sel_i];
  assign O2_o = rd_q[O2Sel_i];
`endif
endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file: reference model pushes expectations, drained after each edge.
module tb_param_reg_file;
  localparam int W = 16, N = 8, LW = 8, NL = 2, SW = 3;

  logic          clk = 1'b0, rst = 1'b1;
  logic [W-1:0]  din = '0;
  logic [NL-1:0] lane = '0;
  logic [1:0]    fs = '0, fs6 = '0;
  logic          en = 1'b0, en6 = 1'b0;
  logic [N-1:0]  ren = '0;
  logic [5:0]    ren6 = '0;
  logic [SW-1:0] s1 = '0, s2 = '0, s1b = '0, s2b = '0;
  logic [W-1:0]  o1, o2, o1b, o2b;
  logic          wrap, zero, wrapb, zerob;

  param_reg_file #(.WIDTH(W), .NUM_REGS(N), .LANE_W(LW)) dut (
    .clock_i(clk), .reset_i(rst), .in_i(din), .lane_en_i(lane), .fun_sel_i(fs), .en_i(en),
    .reg_en_i(ren), .O1Sel_i(s1), .O2Sel_i(s2), .O1_o(o1), .O2_o(o2), .wrap_o(wrap), .zero_o(zero));

  param_reg_file #(.WIDTH(W), .NUM_REGS(6), .LANE_W(LW)) dut6 (
    .clock_i(clk), .reset_i(rst), .in_i(din), .lane_en_i(lane), .fun_sel_i(fs6), .en_i(en6),
    .reg_en_i(ren6), .O1Sel_i(s1b), .O2Sel_i(s2b), .O1_o(o1b), .O2_o(o2b), .wrap_o(wrapb), .zero_o(zerob));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  typedef struct {
    string        tag;
    int           idx;   // register index, -1 wrap, -2 zero
    logic [W-1:0] val;
  } exp_t;
  exp_t sb[$];

  logic [W-1:0] m [N];
  logic         mw = 1'b0, mz = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.idx == -1)      chk({e.tag, "/wrap"}, {{(W-1){1'b0}}, wrap}, e.val);
      else if (e.idx == -2) chk({e.tag, "/zero"}, {{(W-1){1'b0}}, zero}, e.val);
      else begin
        s1 = e.idx[SW-1:0];
        #1;
        chk($sformatf("%s/R%0d", e.tag, e.idx), o1, e.val);
      end
    end
  endtask

  // Drive one op, update the model, push every register plus both flags, clock, then drain.
  task automatic op(input string tag, input logic en_v, input logic [1:0] f, input logic [W-1:0] d,
                    input logic [NL-1:0] l, input logic [N-1:0] r, input int peek);
    logic         w, z;
    logic [W-1:0] nv, old_pk;
    w = 1'b0;
    z = 1'b0;
    @(negedge clk);
    fs = f; din = d; lane = l; ren = r; en = en_v;
    old_pk = (peek >= 0) ? m[peek] : '0;
    if (en_v) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          nv = m[i];
          case (f)
            2'b00: nv = '0;
            2'b01: for (int k = 0; k < NL; k++) if (l[k]) nv[k*LW +: LW] = d[k*LW +: LW];
            2'b10: begin nv = m[i] - 16'd1; if (m[i] == 16'h0000) w = 1'b1; end
            default: begin nv = m[i] + 16'd1; if (m[i] == 16'hFFFF) w = 1'b1; end
          endcase
          if (nv == 16'h0000) z = 1'b1;
          m[i] = nv;
        end
      end
      if (r != '0) begin mw = w; mz = z; end
    end
    if (peek >= 0) begin
      s1 = peek[SW-1:0];
      s2 = peek[SW-1:0];
      #1;
`ifdef RF_BYPASS_EN
      chk({tag, "/byp_O1"}, o1, m[peek]);
      chk({tag, "/byp_O2"}, o2, m[peek]);
`else
      chk({tag, "/pre_O1"}, o1, old_pk);
      chk({tag, "/pre_O2"}, o2, old_pk);
`endif
    end
    for (int i = 0; i < N; i++) sb.push_back('{tag, i, m[i]});
    sb.push_back('{tag, -1, {{(W-1){1'b0}}, mw}});
    sb.push_back('{tag, -2, {{(W-1){1'b0}}, mz}});
    @(posedge clk);
    #1;
    en = 1'b0;
    if (peek >= 0) begin
      chk({tag, "/post_O2"}, o2, m[peek]);
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < N; i++) m[i] = '0;
    #1;
    chk("rst/O1", o1, 16'h0000);
    chk("rst/wrap", {15'd0, wrap}, 16'd0);
    chk("rst/zero", {15'd0, zero}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Lane-masked loads of R2
    op("ld_r2_all",   1'b1, 2'b01, 16'hABCD, 2'b11, 8'b0000_0100, -1);
    op("ld_r2_hi",    1'b1, 2'b01, 16'h5500, 2'b10, 8'b0000_0100, -1);
    op("ld_r2_none",  1'b1, 2'b01, 16'h9999, 2'b00, 8'b0000_0100, -1);

    // Wrap on inc / dec of R5
    op("ld_r5",       1'b1, 2'b01, 16'hFFFF, 2'b11, 8'b0010_0000, -1);
    op("inc_r5_wrap", 1'b1, 2'b11, 16'h0000, 2'b00, 8'b0010_0000, -1);
    op("dec_r5_wrap", 1'b1, 2'b10, 16'h0000, 2'b00, 8'b0010_0000, -1);

    // Multi-hot inc, then en=0 hold
    op("ld_r1",       1'b1, 2'b01, 16'h0004, 2'b11, 8'b0000_0010, -1);
    op("ld_r2",       1'b1, 2'b01, 16'h0009, 2'b11, 8'b0000_0100, -1);
    op("inc_r1r2",    1'b1, 2'b11, 16'h0000, 2'b00, 8'b0000_0110, -1);
    op("en0_hold",    1'b0, 2'b11, 16'h0000, 2'b00, 8'b0000_0110, -1);

    // Same-register read on both ports during a load
    op("ld_r1_peek",  1'b1, 2'b01, 16'h00FF, 2'b11, 8'b0000_0010, 1);

    // Flags to 1/1, then async reset mid-cycle
    op("ld_r3",       1'b1, 2'b01, 16'h1234, 2'b11, 8'b0000_1000, -1);
    op("inc_r5_wrap2",1'b1, 2'b11, 16'h0000, 2'b00, 8'b0010_0000, -1);
    @(negedge clk);
    s1 = 3'd3;
    #1;
    chk("arst/pre_O1", o1, 16'h1234);
    #1;
    rst = 1'b1;
    #1;
    chk("arst/O1", o1, 16'h0000);
    chk("arst/wrap", {15'd0, wrap}, 16'd0);
    chk("arst/zero", {15'd0, zero}, 16'd0);
    fs = 2'b01; din = 16'hFFFF; lane = 2'b11; ren = 8'b0000_1000; en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    #1;
    chk("arst/discard_O1", o1, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) m[i] = '0;
    mw = 1'b0;
    mz = 1'b0;
    op("post_rst_dec",1'b1, 2'b10, 16'h0000, 2'b00, 8'b1000_0000, -1);

    // NUM_REGS=6: out-of-range select, then clear all
    @(negedge clk);
    fs6 = 2'b01; din = 16'h1234; lane = 2'b11; ren6 = 6'b10_0001; en6 = 1'b1;
    @(posedge clk);
    #1;
    en6 = 1'b0;
    s1b = 3'd5; s2b = 3'd7;
    #1;
    chk("n6/ld_R5", o1b, 16'h1234);
    chk("n6/O2_sel7", o2b, 16'h0000);
    s2b = 3'd6;
    #1;
    chk("n6/O2_sel6", o2b, 16'h0000);
    @(negedge clk);
    fs6 = 2'b00; ren6 = 6'b11_1111; en6 = 1'b1;
    @(posedge clk);
    #1;
    en6 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s1b = i[2:0];
      #1;
      chk($sformatf("n6/clr_R%0d", i), o1b, 16'h0000);
    end
    chk("n6/zero", {15'd0, zerob}, 16'd1);
    chk("n6/wrap", {15'd0, wrapb}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
